// File: rtl/gamepad_pkg.sv
// Shared definitions for the gamepad scan scheduler: register map, CSR bits,
// event layout and sequencer states.
package gamepad_pkg;

    localparam int unsigned ADDR_W     = 2;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned PERIOD_W   = 24;
    localparam int unsigned SEL_W      = 4;

    localparam logic [ADDR_W-1:0] ADDR_CSR    = 2'd0;
    localparam logic [ADDR_W-1:0] ADDR_PERIOD = 2'd1;
    localparam logic [ADDR_W-1:0] ADDR_EVENT  = 2'd2;
    localparam logic [ADDR_W-1:0] ADDR_SNAP   = 2'd3;

    localparam int unsigned CSR_EN     = 0;
    localparam int unsigned CSR_IRQ_EN = 1;
    localparam int unsigned CSR_EMPTY  = 2;
    localparam int unsigned CSR_FULL   = 3;
    localparam int unsigned CSR_OVF    = 4;

    localparam logic [PERIOD_W-1:0] PERIOD_RST = 24'h0F4240;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        SCAN = 2'd2,
        CMP  = 2'd3
    } state_t;

    // Event word: bit31 valid, bits[27:24] pad index, low bits new pad value
    typedef struct packed {
        logic        valid;
        logic [2:0]  rsvd;
        logic [3:0]  pad;
        logic [23:0] value;
    } evt_t;

endpackage

// File: rtl/gamepad_evt_fifo.sv
// Synchronous event FIFO with occupancy counter; a push into a full FIFO is
// dropped unless a pop frees a slot in the same cycle.
module gamepad_evt_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] head_c,
    output logic             empty_c,
    output logic             full_c,
    output logic             drop_c
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    // Flag and handshake decode
    always_comb begin
        empty_c = (count == '0);
        full_c  = (count == CNT_W'(DEPTH));
        do_pop  = pop && !empty_c;
        do_push = push && (!full_c || do_pop);
        drop_c  = push && !do_push;
        head_c  = mem[rd_ptr];
    end

    // Storage write
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (do_push && !do_pop)      count <= count + CNT_W'(1);
            else if (!do_push && do_pop) count <= count - CNT_W'(1);
        end
    end

endmodule

// File: rtl/gamepad_sched.sv
// Periodic gamepad scan scheduler: triggers the scanner, diffs each pad
// against its snapshot and queues change events behind a small register bus.
module gamepad_sched
    import gamepad_pkg::*;
#(
    parameter int unsigned N_PAD      = 4,
    parameter int unsigned REG_WIDTH  = 12,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic                       scan_run,
    input  logic                       scan_done,
    input  logic [N_PAD*REG_WIDTH-1:0] scan_value,
    input  logic [ADDR_W-1:0]          bus_addr,
    input  logic [DATA_W-1:0]          bus_wdata,
    output logic [DATA_W-1:0]          bus_rdata,
    input  logic                       bus_we,
    input  logic                       bus_cyc,
    output logic                       bus_ack,
    output logic                       irq
);

    localparam int unsigned PAD_W = (N_PAD > 1) ? $clog2(N_PAD) : 1;

    state_t               state;
    state_t               state_nxt;
    logic                 en;
    logic                 irq_en;
    logic                 overflow;
    logic [PERIOD_W-1:0]  period;
    logic [PERIOD_W-1:0]  cnt;
    logic [SEL_W-1:0]     snap_sel;
    logic [PAD_W-1:0]     pad_idx;
    logic [REG_WIDTH-1:0] stage [N_PAD];
    logic [REG_WIDTH-1:0] snap  [N_PAD];
    logic                 bus_busy;

    logic                 bus_start_c;
    logic                 bus_wr_c;
    logic                 evt_pop_c;
    logic                 ovf_clr_c;
    logic                 last_pad_c;
    logic                 evt_push_c;
    evt_t                 evt_c;
    logic [REG_WIDTH-1:0] cur_stage_c;
    logic [REG_WIDTH-1:0] cur_snap_c;
    logic [REG_WIDTH-1:0] sel_snap_c;
    logic [DATA_W-1:0]    rd_data_c;
    logic [DATA_W-1:0]    fifo_head_c;
    logic                 fifo_empty_c;
    logic                 fifo_full_c;
    logic                 fifo_drop_c;
    logic                 wdata_unused;

    assign wdata_unused = ^bus_wdata[DATA_W-1:PERIOD_W];

    // Sequencer state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Sequencer next state; a pass in flight always finishes before IDLE
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (en) state_nxt = WAIT;
            WAIT: begin
                if (!en)             state_nxt = IDLE;
                else if (cnt == '0)  state_nxt = SCAN;
            end
            SCAN: if (scan_done) state_nxt = CMP;
            CMP:  if (last_pad_c) state_nxt = en ? WAIT : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Period counter, pad walker and scanner run request
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            pad_idx  <= '0;
            scan_run <= 1'b0;
        end else begin
            scan_run <= (state_nxt == SCAN);
            if (state_nxt == WAIT && state != WAIT) cnt <= period;
            else if (state == WAIT && cnt != '0)    cnt <= cnt - PERIOD_W'(1);
            if (state == CMP && !last_pad_c) pad_idx <= pad_idx + PAD_W'(1);
            else                             pad_idx <= '0;
        end
    end

    // Current pad select for compare and snapshot readback
    always_comb begin
        cur_stage_c = '0;
        cur_snap_c  = '0;
        sel_snap_c  = '0;
        for (int unsigned p = 0; p < N_PAD; p++) begin
            if (pad_idx == PAD_W'(p)) begin
                cur_stage_c = stage[p];
                cur_snap_c  = snap[p];
            end
            if (snap_sel == SEL_W'(p)) sel_snap_c = snap[p];
        end
        last_pad_c = (pad_idx == PAD_W'(N_PAD - 1));
        evt_push_c = (state == CMP) && (cur_stage_c != cur_snap_c);
        evt_c       = '0;
        evt_c.valid = 1'b1;
        evt_c.pad   = SEL_W'(pad_idx);
        evt_c.value = 24'(cur_stage_c);
    end

    // Staging capture at end of scan; snapshot follows every detected change
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned p = 0; p < N_PAD; p++) begin
                stage[p] <= '0;
                snap[p]  <= '0;
            end
        end else begin
            if (state == SCAN && scan_done) begin
                for (int unsigned p = 0; p < N_PAD; p++) begin
                    stage[p] <= scan_value[p*REG_WIDTH +: REG_WIDTH];
                end
            end
            if (evt_push_c) begin
                for (int unsigned p = 0; p < N_PAD; p++) begin
                    if (pad_idx == PAD_W'(p)) snap[p] <= cur_stage_c;
                end
            end
        end
    end

    gamepad_evt_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (evt_push_c),
        .pop     (evt_pop_c),
        .wdata   (evt_c),
        .head_c  (fifo_head_c),
        .empty_c (fifo_empty_c),
        .full_c  (fifo_full_c),
        .drop_c  (fifo_drop_c)
    );

    // Bus access decode: one access per bus_cyc assertion
    always_comb begin
        bus_start_c = bus_cyc && !bus_busy;
        bus_wr_c    = bus_start_c && bus_we;
        evt_pop_c   = bus_start_c && !bus_we && (bus_addr == ADDR_EVENT);
        ovf_clr_c   = bus_wr_c && (bus_addr == ADDR_CSR) && bus_wdata[CSR_OVF];
        rd_data_c   = '0;
        unique case (bus_addr)
            ADDR_CSR: begin
                rd_data_c[CSR_EN]     = en;
                rd_data_c[CSR_IRQ_EN] = irq_en;
                rd_data_c[CSR_EMPTY]  = fifo_empty_c;
                rd_data_c[CSR_FULL]   = fifo_full_c;
                rd_data_c[CSR_OVF]    = overflow;
            end
            ADDR_PERIOD: rd_data_c = DATA_W'(period);
            ADDR_EVENT:  rd_data_c = fifo_empty_c ? '0 : fifo_head_c;
            ADDR_SNAP:   rd_data_c = DATA_W'(sel_snap_c);
            default:     rd_data_c = '0;
        endcase
    end

    // Control registers; a new overflow wins over a same-cycle clear
    always_ff @(posedge clk) begin
        if (rst) begin
            en       <= 1'b0;
            irq_en   <= 1'b0;
            overflow <= 1'b0;
            period   <= PERIOD_RST;
            snap_sel <= '0;
        end else begin
            if (bus_wr_c) begin
                unique case (bus_addr)
                    ADDR_CSR: begin
                        en     <= bus_wdata[CSR_EN];
                        irq_en <= bus_wdata[CSR_IRQ_EN];
                    end
                    ADDR_PERIOD: period   <= bus_wdata[PERIOD_W-1:0];
                    ADDR_SNAP:   snap_sel <= bus_wdata[SEL_W-1:0];
                    default: ;
                endcase
            end
            overflow <= fifo_drop_c || (overflow && !ovf_clr_c);
        end
    end

    // Bus response, interrupt and access-in-progress tracking
    always_ff @(posedge clk) begin
        if (rst) begin
            bus_busy  <= 1'b0;
            bus_ack   <= 1'b0;
            bus_rdata <= '0;
            irq       <= 1'b0;
        end else begin
            bus_busy  <= bus_cyc;
            bus_ack   <= bus_start_c;
            bus_rdata <= (bus_start_c && !bus_we) ? rd_data_c : '0;
            irq       <= irq_en && !fifo_empty_c;
        end
    end

endmodule

// File: tb/tb_gamepad_sched.sv
// Randomized self-checking bench for gamepad_sched against a queue-based model.
module tb_gamepad_sched;

    localparam int NP = 4;
    localparam int RW = 12;
    localparam logic [1:0] A_CSR = 2'd0, A_PER = 2'd1, A_EVT = 2'd2, A_SNAP = 2'd3;

    logic          clk = 1'b0;
    logic          rst;
    logic          scan_run;
    logic          scan_done;
    logic [NP*RW-1:0] scan_value;
    logic [1:0]    bus_addr;
    logic [31:0]   bus_wdata;
    logic [31:0]   bus_rdata;
    logic          bus_we;
    logic          bus_cyc;
    logic          bus_ack;
    logic          irq;

    int checks = 0;
    int errors = 0;

    // reference model state
    logic [RW-1:0] m_snap [NP];
    logic [31:0]   m_q [$];
    bit            m_ovf, m_en, m_irq_en;
    int            m_period;

    gamepad_sched #(.N_PAD(NP), .REG_WIDTH(RW), .FIFO_DEPTH(8)) dut (
        .clk(clk), .rst(rst), .scan_run(scan_run), .scan_done(scan_done),
        .scan_value(scan_value), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata), .bus_we(bus_we), .bus_cyc(bus_cyc),
        .bus_ack(bus_ack), .irq(irq)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int p = 0; p < NP; p++) m_snap[p] = '0;
        m_q.delete();
        m_ovf = 0; m_en = 0; m_irq_en = 0; m_period = 32'h0F4240;
    endtask

    // each changed pad, in pad order, yields an event unless 8 are already queued
    task automatic model_pass(input logic [NP*RW-1:0] vals);
        logic [RW-1:0] v;
        for (int p = 0; p < NP; p++) begin
            v = vals[p*RW +: RW];
            if (v != m_snap[p]) begin
                if (m_q.size() < 8) m_q.push_back(32'h8000_0000 | (32'(p) << 24) | 32'(v));
                else m_ovf = 1;
                m_snap[p] = v;
            end
        end
    endtask

    function automatic logic [31:0] csr_exp();
        return {27'd0, m_ovf, (m_q.size() == 8), (m_q.size() == 0), m_irq_en, m_en};
    endfunction

    task automatic bus_xfer(input logic we, input logic [1:0] addr, input logic [31:0] wdata,
                            output logic [31:0] rdata);
        int lat;
        bus_cyc = 1'b1; bus_we = we; bus_addr = addr; bus_wdata = wdata;
        lat = 0;
        do begin step(); lat++; end while (!bus_ack && lat < 8);
        chk("ack_latency", 32'(lat), 32'd1);
        rdata = bus_rdata;
        bus_cyc = 1'b0; bus_we = 1'b0;
        step();
        chk("ack_low", 32'(bus_ack), 32'd0);
        chk("rdata_idle", bus_rdata, 32'd0);
    endtask

    task automatic wr(input logic [1:0] addr, input logic [31:0] data);
        logic [31:0] d;
        bus_xfer(1'b1, addr, data, d);
    endtask

    task automatic rd_chk(input string tag, input logic [1:0] addr, input logic [31:0] exp);
        logic [31:0] d;
        bus_xfer(1'b0, addr, 32'd0, d);
        chk(tag, d, exp);
    endtask

    task automatic wait_run(input int limit);
        int c = 0;
        while (!scan_run && c < limit) begin step(); c++; end
        chk("run_wait", 32'(scan_run), 32'd1);
    endtask

    // act as scanner: finish the pending scan with vals
    task automatic do_pass(input logic [NP*RW-1:0] vals, input bit measure);
        int c;
        chk("run_held", 32'(scan_run), 32'd1);
        repeat ($urandom_range(0, 2)) step();
        scan_value = vals; scan_done = 1'b1;
        step();
        scan_done = 1'b0;
        chk("run_drop", 32'(scan_run), 32'd0);
        model_pass(vals);
        if (measure) begin
            c = 0;
            while (!scan_run && c < 2000) begin step(); c++; end
            chk("pass_latency", 32'(c), 32'(NP + 1 + m_period));
        end else begin
            repeat (NP + 2) step();
        end
    endtask

    task automatic drain(input int n);
        logic [31:0] e;
        for (int i = 0; i < n; i++) begin
            e = (m_q.size() > 0) ? m_q.pop_front() : 32'd0;
            rd_chk("event", A_EVT, e);
        end
        chk("irq", 32'(irq), 32'(m_irq_en && (m_q.size() > 0)));
    endtask

    task automatic verify(input int ndrain);
        int p;
        rd_chk("csr", A_CSR, csr_exp());
        chk("irq_pre", 32'(irq), 32'(m_irq_en && (m_q.size() > 0)));
        p = $urandom_range(0, NP - 1);
        wr(A_SNAP, 32'(p));
        rd_chk("snapshot", A_SNAP, 32'(m_snap[p]));
        drain(ndrain);
    endtask

    function automatic logic [NP*RW-1:0] vals_from_model();
        logic [NP*RW-1:0] v;
        for (int p = 0; p < NP; p++) v[p*RW +: RW] = m_snap[p];
        return v;
    endfunction

    initial begin
        logic [NP*RW-1:0] v;
        int acks, highs;
        rst = 1'b1; scan_done = 1'b0; scan_value = '0;
        bus_addr = '0; bus_wdata = '0; bus_we = 1'b0; bus_cyc = 1'b0;
        model_reset();
        repeat (3) step();
        chk("rst_scan_run", 32'(scan_run), 32'd0);
        chk("rst_ack", 32'(bus_ack), 32'd0);
        chk("rst_rdata", bus_rdata, 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        rst = 1'b0;
        step();
        rd_chk("csr_rst", A_CSR, 32'h4);
        rd_chk("period_rst", A_PER, 32'h0F4240);
        rd_chk("snap_rst", A_SNAP, 32'd0);
        rd_chk("evt_empty", A_EVT, 32'd0);
        rd_chk("csr_empty_after_rd", A_CSR, 32'h4);

        // held bus_cyc produces exactly one ack
        bus_cyc = 1'b1; bus_we = 1'b0; bus_addr = A_CSR; acks = 0;
        repeat (5) begin step(); acks += int'(bus_ack); end
        bus_cyc = 1'b0; step();
        chk("one_ack", 32'(acks), 32'd1);

        // single change on pad 1, then an unchanged pass
        wr(A_PER, 32'd10); m_period = 10;
        wr(A_CSR, 32'h3); m_en = 1; m_irq_en = 1;
        wait_run(100);
        v = '0; v[1*RW +: RW] = 12'h001;
        do_pass(v, 1);
        chk("first_event_model", m_q[0], 32'h8100_0001);
        verify(2);
        do_pass(v, 1);
        verify(1);

        // pads 0 and 3 change together
        v[0*RW +: RW] = 12'hABC; v[3*RW +: RW] = 12'h005;
        do_pass(v, 1);
        verify(3);

        // random passes with partial draining
        repeat (8) begin
            for (int p = 0; p < NP; p++)
                v[p*RW +: RW] = ($urandom_range(0, 1) != 0) ? 12'($urandom_range(0, 4095)) : m_snap[p];
            do_pass(v, 1);
            verify($urandom_range(0, 3));
        end
        drain(m_q.size() + 1);

        // overflow with PERIOD=0
        wr(A_PER, 32'd0); m_period = 0;
        repeat (3) begin
            v = vals_from_model();
            for (int p = 0; p < NP; p++) v[p*RW +: RW] = v[p*RW +: RW] + 12'd1;
            do_pass(v, 1);
        end
        rd_chk("csr_overflow", A_CSR, csr_exp());
        wr(A_CSR, 32'h13); m_ovf = 0;
        rd_chk("csr_w1c", A_CSR, csr_exp());
        drain(9);

        // en cleared while scanning: pass completes, then idle
        wr(A_CSR, 32'h2); m_en = 0;
        chk("run_after_en_clr", 32'(scan_run), 32'd1);
        v = vals_from_model();
        v[0*RW +: RW] = ~v[0*RW +: RW]; v[2*RW +: RW] = v[2*RW +: RW] ^ 12'h0F0;
        do_pass(v, 0);
        highs = 0;
        repeat (40) begin step(); highs += int'(scan_run); end
        chk("idle_no_run", 32'(highs), 32'd0);
        verify(3);

        // en cleared during the wait period
        wr(A_PER, 32'd30); m_period = 30;
        wr(A_CSR, 32'h3); m_en = 1;
        wait_run(100);
        do_pass(vals_from_model(), 0);
        wr(A_CSR, 32'h2); m_en = 0;
        highs = 0;
        repeat (60) begin step(); highs += int'(scan_run); end
        chk("wait_abort_no_run", 32'(highs), 32'd0);

        // reset during a scan; late scan_done must be ignored
        wr(A_PER, 32'd2); m_period = 2;
        wr(A_CSR, 32'h3); m_en = 1;
        wait_run(100);
        scan_value = '1;
        rst = 1'b1;
        step();
        chk("rst_drops_run", 32'(scan_run), 32'd0);
        rst = 1'b0; scan_done = 1'b1;
        step();
        scan_done = 1'b0;
        model_reset();
        highs = 0;
        repeat (20) begin step(); highs += int'(scan_run); end
        chk("post_rst_no_run", 32'(highs), 32'd0);
        rd_chk("csr_post_rst", A_CSR, 32'h4);
        rd_chk("period_post_rst", A_PER, 32'h0F4240);
        rd_chk("evt_post_rst", A_EVT, 32'd0);
        for (int p = 0; p < NP; p++) begin
            wr(A_SNAP, 32'(p));
            rd_chk("snap_post_rst", A_SNAP, 32'd0);
        end
        chk("irq_post_rst", 32'(irq), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gamepad_sched.md
GAMEPAD_SCHED -- requirements
Module: gamepad_sched

Interface
REQ-001 SHALL have parameter N_PAD, default 4: number of pad slots in the scanner value vector.
REQ-002 SHALL have parameter REG_WIDTH, default 12: bits per pad.
REQ-003 SHALL have parameter FIFO_DEPTH, default 8 (power of two): event FIFO entries.
REQ-004 SHALL have port clk, input, 1: clock.
REQ-005 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-006 SHALL have port scan_run, output, 1: run request to the scanner.
REQ-007 SHALL have port scan_done, input, 1: one-cycle pulse when the scanner completes a full pass over all pads.
REQ-008 SHALL have port scan_value, input, N_PAD*REG_WIDTH: latest per-pad values; pad p occupies bits [p*REG_WIDTH +: REG_WIDTH]; 1 means pressed.
REQ-009 SHALL have ports bus_addr (input, 2), bus_wdata (input, 32), bus_rdata (output, 32), bus_we (input, 1), bus_cyc (input, 1), bus_ack (output, 1): register bus.
REQ-010 SHALL have port irq, output, 1: event-pending interrupt.

Function
REQ-011 SHALL implement registers: 0 CSR (bit0 en, bit1 irq_en, bit2 fifo_empty RO, bit3 fifo_full RO, bit4 overflow sticky, write-1-clear); 1 PERIOD (24-bit, in clk cycles); 2 EVENT (read pops); 3 SNAPSHOT_SEL (write pad index, read returns that pad's current snapshot).
REQ-012 SHALL ack every bus cycle exactly one cycle after bus_cyc rises, with bus_rdata valid in the ack cycle and zero otherwise, and SHALL accept no new access until bus_cyc drops.
REQ-013 SHALL sequence with FSM states IDLE, WAIT, SCAN and CMP.
REQ-014 IDLE->WAIT SHALL occur when en=1, loading the period counter with PERIOD.
REQ-015 WAIT SHALL decrement the counter to 0, then go to SCAN.
REQ-016 SCAN SHALL hold scan_run=1 until scan_done, then capture scan_value into a staging register, deassert scan_run and go to CMP.
REQ-017 CMP SHALL visit pads 0..N_PAD-1, one per cycle.
REQ-018 In CMP, a pad whose staged value differs from its snapshot SHALL push event {bit31=1, bits[27:24]=pad index, bits[REG_WIDTH-1:0]=new value}, and the snapshot SHALL be updated.
REQ-019 After pad N_PAD-1, CMP SHALL go to WAIT, reloading PERIOD.
REQ-020 PERIOD=0 SHALL make WAIT last exactly one cycle.
REQ-021 en cleared in WAIT SHALL go to IDLE immediately.
REQ-022 en cleared in SCAN or CMP SHALL let the pass complete, then go to IDLE.
REQ-023 A push into a full FIFO SHALL drop the event and set overflow; the snapshot still SHALL update.
REQ-024 An EVENT read on an empty FIFO SHALL return 0 (bit31=0) and SHALL not move pointers.
REQ-025 A push and pop in the same cycle SHALL both take effect, with occupancy unchanged.
REQ-026 irq SHALL equal irq_en AND NOT fifo_empty, registered (one cycle after FIFO state change).
REQ-027 A write to CSR overflow with 1 in the same cycle as a new overflow SHALL leave overflow set.

Reset
REQ-028 On rst, FSM SHALL go to IDLE, scan_run=0, bus_ack=0, bus_rdata=0, irq=0.
REQ-029 On rst, CSR SHALL clear to 0, PERIOD SHALL reset to 0x0F4240, and SNAPSHOT_SEL SHALL clear to 0.
REQ-030 On rst, snapshots SHALL clear to 0 and the FIFO SHALL be emptied.
REQ-031 rst mid-SCAN SHALL drop scan_run in the following cycle, and a late scan_done SHALL be ignored.

Structure
REQ-032 Register addresses, CSR bit positions, event field offsets and FSM state encodings SHALL live in shared package gamepad_pkg.
REQ-033 The event FIFO SHALL be a separate sub-module gamepad_evt_fifo (synchronous, occupancy counter, full/empty flags).

Verification
REQ-034 Scenario: en=1, PERIOD=10, scan_value pad1=0x001 -> one event 0x81000001; the second pass with same value -> no event.
REQ-035 Scenario: pads 0 and 3 change in one pass -> events for pad 0 then pad 3, in order; irq rises when irq_en=1.
REQ-036 Scenario: FIFO_DEPTH=8 full, a 9th change occurs -> overflow=1, FIFO still holds the first 8; W1C clears overflow.
REQ-037 Scenario: EVENT read when empty -> 0x00000000, fifo_empty stays 1.
REQ-038 Scenario: en cleared mid-SCAN -> scan_run holds until scan_done, CMP completes, FSM reaches IDLE with no further scan_run.
REQ-039 Scenario: rst asserted during SCAN -> scan_run=0 the next cycle, snapshots 0, no event from a late scan_done.
